// File: rtl/cpu64_l1_refill_seq_pkg.sv
// cpu64_l1_refill_seq_pkg: line state codes, line geometry and sequencer state encoding
package cpu64_l1_refill_seq_pkg;
  typedef enum logic [1:0] {MESI_N = 2'd0, MESI_B = 2'd1, MESI_T = 2'd2, MESI_TT = 2'd3} mesi_e;
  localparam int LINE_BYTES     = 64;
  localparam int WORDS_PER_LINE = 8;
  localparam int OFF_W          = $clog2(LINE_BYTES);
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WB     = 3'd1,
    ST_WB_ACK = 3'd2,
    ST_FILL   = 3'd3,
    ST_DONE   = 3'd4
  } seq_state_e;
endpackage

// File: rtl/cpu64_l1_beat_ctr.sv
// cpu64_l1_beat_ctr: 3-bit line beat counter with clear/advance and last-beat flag
module cpu64_l1_beat_ctr
  import cpu64_l1_refill_seq_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       adv_i,
  output logic [2:0] cnt_o,
  output logic       last_o
);
  logic [2:0] cnt_d, cnt_q;
  // clear wins over advance; 7 wraps naturally to 0
  always_comb cnt_d = clr_i ? 3'd0 : adv_i ? cnt_q + 3'd1 : cnt_q;
  // counter register
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_q <= 3'd0;
    else       cnt_q <= cnt_d;
  assign cnt_o  = cnt_q;
  assign last_o = cnt_q == 3'(WORDS_PER_LINE - 1);
endmodule

// File: rtl/cpu64_l1_refill_seq.sv
// cpu64_l1_refill_seq: L1 victim writeback + line fill sequencer; optional CPU64_L1_REFILL_PERF_EN adds perf counters
module cpu64_l1_refill_seq
  import cpu64_l1_refill_seq_pkg::*;
#(
  parameter int SETS    = 32,
  parameter int WAYS    = 8,
  parameter int INDEX_W = 5,
  parameter int TAG_W   = 53
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [INDEX_W-1:0] req_index_i,
  input  logic [2:0]         req_way_i,
  input  logic [TAG_W-1:0]   req_tag_i,
  input  logic [1:0]         req_state_i,
  output logic [INDEX_W-1:0] arr_index_o,
  output logic [2:0]         arr_word_o,
  output logic [2:0]         arr_way_o,
  output logic               arr_we_o,
  output logic [1:0]         arr_state_o,
  output logic [7:0]         arr_be_o,
  output logic [TAG_W-1:0]   arr_tag_o,
  output logic [63:0]        arr_wdata_o,
  input  logic [63:0]        arr_rdata_i,
  input  logic [TAG_W-1:0]   arr_tag_i,
  input  logic [1:0]         arr_state_i,
  output logic               c_valid_o,
  input  logic               c_ready_i,
  output logic [63:0]        c_addr_o,
  output logic [63:0]        c_data_o,
  output logic               c_last_o,
  input  logic               rel_ack_i,
  input  logic               d_valid_i,
  output logic               d_ready_o,
  input  logic [63:0]        d_data_i,
  input  logic               d_denied_i,
  output logic               done_o,
  output logic               err_o
`ifdef CPU64_L1_REFILL_PERF_EN
  ,
  output logic [31:0]        perf_fill_cnt_o,
  output logic [31:0]        perf_wb_cnt_o,
  output logic [15:0]        perf_deny_cnt_o
`endif
);
  if (SETS != (1 << INDEX_W) || WAYS != 8 || TAG_W != 64 - INDEX_W - OFF_W) begin : g_cfg_err
    $error("cpu64_l1_refill_seq: inconsistent SETS/WAYS/INDEX_W/TAG_W");
  end
  seq_state_e         state_q, state_d;
  logic [INDEX_W-1:0] idx_q, idx_d;
  logic [2:0]         way_q, way_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [1:0]         st_q, st_d;
  logic [63:0]        addr_q, addr_d;
  logic               err_q, err_d;
  logic               cnt_clr, cnt_adv, cnt_last;
  logic [2:0]         cnt;
  cpu64_l1_beat_ctr u_ctr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (cnt_clr),
    .adv_i  (cnt_adv),
    .cnt_o  (cnt),
    .last_o (cnt_last)
  );
  // next state and outputs; in IDLE the array address follows the request so the victim state is visible in the accept cycle
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    way_d       = way_q;
    tag_d       = tag_q;
    st_d        = st_q;
    addr_d      = addr_q;
    err_d       = err_q;
    cnt_clr     = 1'b0;
    cnt_adv     = 1'b0;
    req_ready_o = 1'b0;
    arr_index_o = idx_q;
    arr_way_o   = way_q;
    arr_word_o  = cnt;
    arr_we_o    = 1'b0;
    arr_state_o = MESI_N;
    arr_tag_o   = '0;
    arr_wdata_o = '0;
    c_valid_o   = 1'b0;
    c_data_o    = '0;
    c_last_o    = 1'b0;
    d_ready_o   = 1'b0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        arr_index_o = req_index_i;
        arr_way_o   = req_way_i;
        cnt_clr     = 1'b1;
        if (req_valid_i) begin
          idx_d   = req_index_i;
          way_d   = req_way_i;
          tag_d   = req_tag_i;
          st_d    = req_state_i;
          err_d   = 1'b0;
          addr_d  = arr_state_i == MESI_TT ? {arr_tag_i, req_index_i, {OFF_W{1'b0}}} : addr_q;
          state_d = arr_state_i == MESI_TT ? ST_WB : ST_FILL;
        end
      end
      ST_WB: begin
        c_valid_o = 1'b1;
        c_data_o  = arr_rdata_i;
        c_last_o  = cnt_last;
        cnt_adv   = c_ready_i;
        state_d   = c_ready_i && cnt_last ? ST_WB_ACK : ST_WB;
      end
      ST_WB_ACK: state_d = rel_ack_i ? ST_FILL : ST_WB_ACK;
      ST_FILL: begin
        d_ready_o = 1'b1;
        if (d_valid_i) begin
          cnt_adv     = 1'b1;
          arr_we_o    = !err_q;
          arr_wdata_o = err_q ? '0 : d_data_i;
          arr_tag_o   = err_q ? '0 : tag_q;
          arr_state_o = !err_q && cnt_last && !d_denied_i ? st_q : MESI_N;
          err_d       = err_q | d_denied_i;
          state_d     = cnt_last ? ST_DONE : ST_FILL;
        end
      end
      ST_DONE: begin
        done_o  = 1'b1;
        err_o   = err_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  assign arr_be_o = {8{arr_we_o}};
  assign c_addr_o = addr_q;
  // sequencer registers; reset abandons any fill in progress
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      way_q   <= '0;
      tag_q   <= '0;
      st_q    <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      way_q   <= way_d;
      tag_q   <= tag_d;
      st_q    <= st_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
`ifdef CPU64_L1_REFILL_PERF_EN
  logic [31:0] perf_fill_cnt_q, perf_fill_cnt_d, perf_wb_cnt_q, perf_wb_cnt_d;
  logic [15:0] perf_deny_cnt_q, perf_deny_cnt_d;
  // saturating event counters: clean completion, writeback finished, denied completion
  always_comb begin
    perf_fill_cnt_d = perf_fill_cnt_q + 32'(state_q == ST_DONE && !err_q && !(&perf_fill_cnt_q));
    perf_wb_cnt_d   = perf_wb_cnt_q + 32'(state_q == ST_WB && state_d == ST_WB_ACK && !(&perf_wb_cnt_q));
    perf_deny_cnt_d = perf_deny_cnt_q + 16'(state_q == ST_DONE && err_q && !(&perf_deny_cnt_q));
  end
  // perf counter registers
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      perf_fill_cnt_q <= '0;
      perf_wb_cnt_q   <= '0;
      perf_deny_cnt_q <= '0;
    end else begin
      perf_fill_cnt_q <= perf_fill_cnt_d;
      perf_wb_cnt_q   <= perf_wb_cnt_d;
      perf_deny_cnt_q <= perf_deny_cnt_d;
    end
  assign perf_fill_cnt_o = perf_fill_cnt_q;
  assign perf_wb_cnt_o   = perf_wb_cnt_q;
  assign perf_deny_cnt_o = perf_deny_cnt_q;
`endif
endmodule
